// File: rtl/alu_pkg.sv
// Shared ALU field layout for the switch bank and the conditioner's state encoding.
// The switch-to-operand mapping lives here so the ALU and display stages agree on it.
package alu_pkg;

    localparam int unsigned ALU_W     = 4;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned A_LSB     = 0;
    localparam int unsigned B_LSB     = 4;
    localparam int unsigned M_BIT     = 8;
    localparam int unsigned OP_LSB    = 9;
    localparam int unsigned FIELD_MSB = OP_LSB + OP_W - 1;

    typedef logic [OP_W-1:0] alu_op_t;

    typedef struct packed {
        alu_op_t          sel;
        logic             m;
        logic [ALU_W-1:0] b;
        logic [ALU_W-1:0] a;
    } alu_fields_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } cond_state_t;

    // Split the low switch bits into ALU operand fields
    function automatic alu_fields_t decode_fields(input logic [FIELD_MSB:0] sw);
        alu_fields_t f;
        f.a   = sw[A_LSB +: ALU_W];
        f.b   = sw[B_LSB +: ALU_W];
        f.m   = sw[M_BIT];
        f.sel = sw[OP_LSB +: OP_W];
        return f;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Per-bit flip-flop chain bringing an asynchronous vector into the clk domain.
// Stages are plain flops back to back; o_q is the last stage.
module bit_sync #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < int'(STAGES); i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/alu_input_conditioner.sv
// Synchronises and debounces the slide switches as one vector, then publishes the
// stable image, its ALU operand fields, and a pulse/count on every accepted change.
module alu_input_conditioner
    import alu_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = 8
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESETN,
    input  logic [SW_WIDTH-1:0]  sw_raw,
    output logic [SW_WIDTH-1:0]  sw_stable,
    output logic [ALU_W-1:0]     op_a,
    output logic [ALU_W-1:0]     op_b,
    output logic                 op_m,
    output alu_op_t              op_sel,
    output logic                 upd_pulse,
    output logic [CNT_WIDTH-1:0] upd_count,
    output logic                 settling
);

    localparam int unsigned   CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0]  w_sw_sync;
    logic [SW_WIDTH-1:0]  r_sw_stable;
    logic [SW_WIDTH-1:0]  r_cand;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_upd_pulse;
    logic [CNT_WIDTH-1:0] r_upd_count;
    logic                 r_settling;
    cond_state_t          r_state;
    alu_fields_t          w_fields;

    bit_sync #(
        .WIDTH  (SW_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .i_d   (sw_raw),
        .o_q   (w_sw_sync)
    );

    // Qualify a candidate vector over a full window; any bounce restarts the window
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state     <= ST_IDLE;
            r_sw_stable <= '0;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_upd_pulse <= 1'b0;
            r_upd_count <= '0;
            r_settling  <= 1'b0;
        end else begin
            r_upd_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_settling <= 1'b0;
                    if (w_sw_sync != r_sw_stable) begin
                        r_cand     <= w_sw_sync;
                        r_cnt      <= '0;
                        r_settling <= 1'b1;
                        r_state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_sw_sync != r_cand) begin
                        r_cand <= w_sw_sync;
                        r_cnt  <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        if (r_cand != r_sw_stable) begin
                            r_sw_stable <= r_cand;
                            r_upd_pulse <= 1'b1;
                            r_upd_count <= r_upd_count + CNT_WIDTH'(1);
                        end
                        r_settling <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_settling <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand fields are straight slices of the stable image
    assign w_fields  = decode_fields(r_sw_stable[FIELD_MSB:0]);

    assign sw_stable = r_sw_stable;
    assign op_a      = w_fields.a;
    assign op_b      = w_fields.b;
    assign op_m      = w_fields.m;
    assign op_sel    = w_fields.sel;
    assign upd_pulse = r_upd_pulse;
    assign upd_count = r_upd_count;
    assign settling  = r_settling;

endmodule

// File: doc/alu_input_conditioner.md
Name: alu_input_conditioner

Overview:
Upstream stage of the ALU datapath on the Nexys board. It synchronises the 16 raw slide switches into the CLK100MHZ domain and debounces them as one vector. It publishes a stable switch image plus the decoded ALU operand fields (a, b, M, alu_op), so the ALU and seven-segment stages never see metastable or bouncing inputs. It also emits a one-cycle pulse and a wrapping count on every accepted change, for display and refresh triggering.

Parameters:
SW_WIDTH, 16, width of the raw switch vector
SYNC_STAGES, 2, flip-flop depth of the synchroniser chain per bit (legal values >= 2)
DEBOUNCE_CYCLES, 1000000, number of consecutive unchanged clocks required to accept a new value (10 ms at 100 MHz; legal values >= 2)
CNT_WIDTH, 8, width of the accepted-change counter

Ports:
CLK100MHZ  input  1  system clock, 100 MHz
CPU_RESETN  input  1  reset, asynchronous assert, active-low
sw_raw  input  SW_WIDTH  raw slide switches, asynchronous to the clock
sw_stable  output  SW_WIDTH  debounced switch image
op_a  output  4  sw_stable[3:0]
op_b  output  4  sw_stable[7:4]
op_m  output  1  sw_stable[8]
op_sel  output  2  sw_stable[10:9]
upd_pulse  output  1  single-cycle strobe when sw_stable changes value
upd_count  output  CNT_WIDTH  number of accepted changes, wraps modulo 2^CNT_WIDTH
settling  output  1  high while a candidate value is being qualified

Interface decision:
One clock. Reset is asynchronous and active-low, on port CPU_RESETN, clocked by CLK100MHZ.

Behaviour:
- Reset (CPU_RESETN=0, asynchronous):
  - all synchroniser flops = 0, sw_stable = 0, candidate register = 0, debounce counter = 0
  - upd_pulse = 0, upd_count = 0, settling = 0, state = IDLE
  - op_* fields follow sw_stable, so they are 0.
- Synchroniser: per-bit chain of SYNC_STAGES flops; sw_sync is the last stage. No logic between stages.
- Operand fields are pure combinational slices of sw_stable. They carry no extra latency.
- FSM, state IDLE:
  - If sw_sync == sw_stable: stay in IDLE.
  - Else: cand <= sw_sync, cnt <= 0, go to SETTLE.
  - settling = 0 in IDLE.
- FSM, state SETTLE (settling = 1). Evaluated in this priority order each clock:
  1. sw_sync != cand: cand <= sw_sync, cnt <= 0, stay in SETTLE. This is a bounce and restarts the window.
  2. cnt == DEBOUNCE_CYCLES-1 and cand != sw_stable: sw_stable <= cand, upd_pulse = 1 for exactly this clock, upd_count <= upd_count+1, go to IDLE.
  3. cnt == DEBOUNCE_CYCLES-1 and cand == sw_stable: the glitch returned to the old value. Go to IDLE with no pulse and no count change.
  4. Otherwise: cnt <= cnt+1.
- Latency: a clean raw change first sampled at edge t appears on sw_stable, with upd_pulse, at edge t+SYNC_STAGES+DEBOUNCE_CYCLES.
- Multi-bit changes are accepted atomically. sw_stable never shows a partial mix of old and new bits.
- upd_pulse is never high on two consecutive clocks. After any commit, at least one IDLE clock occurs before the next SETTLE.
- upd_count wraps from 2^CNT_WIDTH-1 to 0 with no sticky flag.
- Reset mid-SETTLE discards the candidate. After release, non-zero switches are qualified again from scratch and produce exactly one pulse.
- Counter width is clog2(DEBOUNCE_CYCLES). No counter saturates or wraps inside a window.

Decomposition:
- Package alu_pkg holds:
  - ALU_W = 4
  - typedef alu_op_t (2-bit)
  - field index constants A_LSB=0, B_LSB=4, M_BIT=8, OP_LSB=9
- alu_input_conditioner uses these constants for all slicing.
- One sub-module: bit_sync, a parameterised width × SYNC_STAGES synchroniser bank with async active-low reset. The FSM, counter and registers stay in the top.

Test Plan:
Use DEBOUNCE_CYCLES=8, SYNC_STAGES=2, CNT_WIDTH=8 for all scenarios.
1. Reset with sw_raw=0x0000, then release and hold 20 clocks -> all outputs 0, settling=0, no upd_pulse.
2. sw_raw 0x0000→0x0235, first sampled at edge t -> sw_stable=0x0235 at edge t+10; op_a=5, op_b=3, op_m=0, op_sel=1; one upd_pulse; upd_count=1.
3. sw_raw toggles 0x0001/0x0000 every 3 clocks for 40 clocks, then holds 0x0001 -> no pulse during toggling; exactly one commit, 8 clocks after the last toggle reaches sw_sync; upd_count +1.
4. From stable 0x0010, a 3-clock glitch to 0x0011 then back to 0x0010 -> settling rises, then falls after the window; sw_stable stays 0x0010; no pulse; upd_count unchanged.
5. Assert CPU_RESETN asynchronously mid-SETTLE (between clock edges) with sw_raw=0x07FF -> outputs go to 0 immediately, without waiting for a clock edge; after release, sw_stable=0x07FF exactly 10 clocks later with one pulse.
6. Perform 256 clean accepted changes -> upd_count wraps to 0 on the 256th; upd_pulse never asserted on consecutive clocks.
